// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the rv32im fetch stage.
// Holds the fetch address, advances it under a valid/ready handshake,
// applies trap/branch redirects with fixed priority, rejects misaligned
// branch targets, supports halt/resume and counts accepted fetches.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   fetch_valid         pc is a valid fetch request
//   fetch_ready         instruction memory accepts pc this cycle
//   stall               blocks sequential advance only
//   br_valid/br_target  branch/jump redirect
//   trap_valid/trap_target  trap redirect (highest priority, also wakes HALT)
//   halt, resume        enter / leave HALT (resume wins when both)
//   pc                  current fetch address
//   halted              core is in HALT
//   misalign            one-cycle pulse when a branch target is rejected
//   misalign_addr       last rejected branch target
//   fetch_count         accepted fetch count, wraps
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr,
  output logic [XLEN-1:0] fetch_count
);

  // Low target bits that must be zero for a legal redirect.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] PC_INC     = XLEN'(INC);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc_n;
  logic [XLEN-1:0] count_n;
  logic [XLEN-1:0] mis_addr_n;
  logic            mis_n;
  logic            accept_c;
  logic            br_aligned_c;

  assign accept_c     = fetch_ready && !stall;
  assign br_aligned_c = (br_target & ALIGN_MASK) == '0;

  // Next-state, next-pc and counter logic.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    count_n    = fetch_count;
    mis_n      = 1'b0;
    mis_addr_n = misalign_addr;
    unique case (state)
      ST_BOOT: begin
        state_n = ST_RUN;
      end
      ST_RUN: begin
        // The count tracks handshakes even when a redirect wins over the advance.
        if (accept_c) begin
          count_n = fetch_count + XLEN'(1);
        end
        if (trap_valid) begin
          pc_n = trap_target & ~ALIGN_MASK;
        end else if (br_valid) begin
          if (br_aligned_c) begin
            pc_n = br_target;
          end else begin
            mis_n      = 1'b1;
            mis_addr_n = br_target;
          end
        end else if (accept_c) begin
          pc_n = pc + PC_INC;
        end
        if (halt) begin
          state_n = ST_HALT;
        end
      end
      ST_HALT: begin
        if (trap_valid) begin
          pc_n    = trap_target & ~ALIGN_MASK;
          state_n = ST_RUN;
        end else if (resume) begin
          state_n = ST_RUN;
        end
      end
      default: begin
        state_n = ST_BOOT;
      end
    endcase
  end

  // State and output registers; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_BOOT;
      pc            <= RESET_VECTOR;
      fetch_count   <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
      fetch_valid   <= 1'b0;
      halted        <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      fetch_count   <= count_n;
      misalign      <= mis_n;
      misalign_addr <= mis_addr_n;
      fetch_valid   <= (state_n == ST_RUN);
      halted        <= (state_n == ST_HALT);
    end
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage of the rv32im core, replacing the single-register PC with write enable. It holds the architectural fetch address and advances it sequentially under a valid/ready fetch handshake. It applies branch and trap redirects with fixed priority, checks target alignment, supports halt/resume, and counts accepted fetches. It sits between the branch/trap logic in execute and the instruction-memory fetch port.

## Interface
- XLEN, 32, width of PC, targets and fetch counter
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset (XLEN bits)
- INC, 4, sequential increment in bytes
- ALIGN_BITS, 2, number of low target bits that must be zero (1 for compressed support)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- fetch_valid  output  1  pc is a valid fetch request
- fetch_ready  input  1  instruction memory accepts pc this cycle
- stall  input  1  blocks sequential advance only
- br_valid  input  1  branch/jump redirect request
- br_target  input  XLEN  branch/jump target
- trap_valid  input  1  trap/exception redirect request
- trap_target  input  XLEN  trap vector
- halt  input  1  request halt
- resume  input  1  leave HALT
- pc  output  XLEN  current fetch address (registered)
- halted  output  1  state == HALT
- misalign  output  1  one-cycle pulse: branch target rejected
- misalign_addr  output  XLEN  last rejected branch target
- fetch_count  output  XLEN  number of accepted fetches, wraps modulo 2^XLEN

## Operation
- States: BOOT, RUN, HALT. All outputs are registered or decoded from the state only.
- Reset, sampled low on an edge, sets these values: pc=RESET_VECTOR, state=BOOT, fetch_count=0, misalign=0, misalign_addr=0. Resulting outputs: fetch_valid=0, halted=0. Reset overrides every other input, including mid-redirect and mid-halt.
- BOOT: fetch_valid=0, PC holds, all requests ignored; always goes to RUN on the next edge.
- RUN: fetch_valid=1. PC update priority per edge:
  1. trap_valid: pc <= trap_target with low ALIGN_BITS forced to 0.
  2. br_valid with aligned target: pc <= br_target.
  3. br_valid with misaligned target (any of low ALIGN_BITS set): pc holds, misalign=1 next cycle, misalign_addr <= br_target.
  4. fetch_ready && !stall: pc <= pc + INC, wrapping modulo 2^XLEN.
  5. Otherwise pc holds.
- Redirects (1–3) apply even when stall=1 or fetch_ready=0; they discard the sequential advance.
- fetch_count increments exactly when fetch_valid && fetch_ready && !stall, including cycles where a redirect overrides the advance.
- halt in RUN: state <= HALT. A redirect in the same cycle is still applied, so pc holds the redirected value in HALT.
- HALT: fetch_valid=0, halted=1, pc holds, br_valid ignored.
  - trap_valid applies the trap target and returns to RUN (trap wakes).
  - Otherwise resume returns to RUN.
  - halt and resume together: resume wins.
- misalign is high for exactly one cycle per rejected branch, and is 0 in every other cycle.

## Timing
- Latency 1: a redirect or advance sampled at edge N is visible on pc after edge N.
- The first edge with reset high moves BOOT→RUN, so fetch_valid rises one cycle after reset release with pc=RESET_VECTOR.
- Back-to-back accepted fetches give one new pc per cycle with no bubbles.
- fetch_valid falls in the cycle after halt is sampled and rises in the cycle after resume or trap is sampled.
- The counter wraps from 2^XLEN−1 to 0 without any flag.

## Test plan
- Reset/boot: hold reset=0 for 3 cycles, then release → pc=0, fetch_valid=0 for one cycle, then 1. With fetch_ready=1: pc=0,4,8,C; fetch_count=4 after 4 accepts.
- Priority: in RUN at pc=0x100, assert trap_valid, trap_target=0x203, br_valid, br_target=0x400, and stall=1 together → next pc=0x200, misalign=0, fetch_count unchanged.
- Misaligned branch: br_target=0x102 at pc=0x40 → pc stays 0x40, misalign=1 for one cycle, misalign_addr=0x102. Then fetch_ready=1 → pc=0x44.
- Wrap-around: with RESET_VECTOR=32'hFFFF_FFF8 and fetch_ready=1 → pc=FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Halt/resume: halt at pc=0x20 with br_valid to 0x80 in the same cycle → halted=1, pc=0x80, fetch_valid=0. br_valid to 0x90 while halted → ignored. resume → fetch_valid=1 at pc=0x80.
- Reset mid-halt: assert reset=0 while in HALT with trap_valid=1 → pc=RESET_VECTOR, halted=0, BOOT on release.
